// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the framebuffer write port between two pixel
// requesters (round-robin) and an optional clear-screen fill engine.
// Optional feature macro: FB_ARB_FILL_EN (fill engine present when defined;
// otherwise fill_start/fill_color are ignored and fill_busy/fill_done are 0).
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   a_req/a_addr/a_data   requester A word, held until a_ack
//   a_ack                 one-cycle pulse: A's word issued or dropped
//   b_*                   same as A, for requester B
//   fill_start/fill_color start a full-buffer fill with one colour
//   fill_busy/fill_done   fill in progress / one-cycle completion pulse
//   wr_ready              controller write window open
//   wr_addr/wr_data/wr_en registered framebuffer write port
//   addr_err              pulse with ack when granted address is out of range
module fb_write_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 24,
    parameter int FB_DEPTH = 19200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ack,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ack,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(FB_DEPTH);

    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic              wr_en_q, wr_en_d;
    logic              err_q, err_d;
    logic              rr_q, rr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              a_elig, b_elig;
    logic              pick_b, grant;
    logic              in_idle, fill_go;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_ok;

    // A word whose ack is showing this cycle is still held by its
    // requester; it must not be granted a second time.
    assign a_elig = a_req & ~a_ack_q;
    assign b_elig = b_req & ~b_ack_q;

    // rr_q = 1 favours B; updated only on an actual grant.
    assign pick_b   = b_elig & (~a_elig | rr_q);
    assign grant    = in_idle & wr_ready & ~fill_go & (a_elig | b_elig);
    assign sel_addr = pick_b ? b_addr : a_addr;
    assign sel_data = pick_b ? b_data : a_data;
    assign sel_ok   = ({1'b0, sel_addr} < DEPTH);

`ifdef FB_ARB_FILL_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_q, last_d;

    assign in_idle   = (state_q == IDLE);
    assign fill_go   = in_idle & fill_start;
    assign fill_busy = busy_q;
    assign fill_done = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // last_q marks that the final location was written last cycle;
    // the following cycle is spent signalling completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (fill_start) state_d = FILL;
            FILL: if (last_q) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            color_q <= color_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end
`else
    logic unused_fill;

    assign in_idle     = 1'b1;
    assign fill_go     = 1'b0;
    assign fill_busy   = 1'b0;
    assign fill_done   = 1'b0;
    assign unused_fill = ^{fill_start, fill_color};
`endif

    always_comb begin
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        wr_en_d   = 1'b0;
        err_d     = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rr_d      = rr_q;
`ifdef FB_ARB_FILL_EN
        cnt_d     = cnt_q;
        color_d   = color_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        last_d    = last_q;
`endif
        // Out-of-range words are acked and dropped, never written.
        if (grant) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
            wr_en_d   = sel_ok;
            err_d     = ~sel_ok;
            a_ack_d   = ~pick_b;
            b_ack_d   = pick_b;
            rr_d      = ~pick_b;
        end
`ifdef FB_ARB_FILL_EN
        if (fill_go) begin
            color_d = fill_color;
            cnt_d   = '0;
            busy_d  = 1'b1;
            last_d  = 1'b0;
        end
        if (state_q == FILL) begin
            if (last_q) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                last_d = 1'b0;
            end else if (wr_ready) begin
                wr_addr_d = cnt_q;
                wr_data_d = color_q;
                wr_en_d   = 1'b1;
                last_d    = (cnt_q == LAST);
                if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
            rr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            wr_en_q   <= wr_en_d;
            err_q     <= err_d;
            rr_q      <= rr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign wr_en    = wr_en_q;
    assign addr_err = err_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule
